axil_mem_req_adapter: RTL and testbench
=======================================

// Module: axil_mem_req_adapter
// PURPOSE
//   Sits between a stallable HLS datapath and an AXI4-Lite slave (axil_ram). Converts a simple
//   one-beat valid/ready load/store request into an AXI4-Lite write (AW+W+B) or read (AR+R).
//   Holds the completed response until the datapath accepts it, so a result is never lost
//   while the core is stalled. One transaction in flight.
// PARAMETERS
//   ADDR_WIDTH  5              AXI/request byte-address width
//   DATA_WIDTH  32             data width
//   STRB_WIDTH  DATA_WIDTH/8   write-strobe width
// PORTS
//   clk            in   1           clock, all logic on rising edge
//   rst            in   1           synchronous, active-low reset
//   req_valid      in   1           request present
//   req_ready      out  1           adapter can accept a request
//   req_wen        in   1           1 = store, 0 = load
//   req_addr       in   ADDR_WIDTH  request address
//   req_wdata      in   DATA_WIDTH  store data
//   req_wstrb      in   STRB_WIDTH  store byte enables
//   resp_valid     out  1           response present
//   resp_ready     in   1           core accepts response (low = core stalled)
//   resp_rdata     out  DATA_WIDTH  load data; 0 for stores
//   resp_err       out  1           1 = AXI resp was SLVERR/DECERR
//   m_axil_aw*/w*/b*/ar*/r*  -      AXI4-Lite master channels (awaddr, awprot, awvalid, awready,
//                                   wdata, wstrb, wvalid, wready, bresp, bvalid, bready, araddr,
//                                   arprot, arvalid, arready, rdata, rresp, rvalid, rready)
// BEHAVIOUR
//   - Reset (rst==0 at edge): state IDLE; all valid/ready outputs 0 except req_ready=1 after reset
//     releases; resp_rdata=0, resp_err=0; awprot/arprot constant 3'b000. Reset mid-transaction
//     aborts it; the slave shares rst and is reset in the same cycle.
//   - FSM states: IDLE, WR, WR_B, RD_A, RD_R, RESP.
//   - IDLE: req_ready=1. On req_valid: latch addr/wdata/wstrb; wen -> WR else RD_A.
//   - WR: awvalid and wvalid rise the cycle after acceptance; each drops independently after its
//     own handshake (aw_done/w_done flags). Both done -> WR_B. Same-cycle AW+W handshake is legal.
//   - WR_B: bready=1; on bvalid capture err=bresp[1], rdata=0 -> RESP.
//   - RD_A: arvalid=1 until arready -> RD_R. RD_R: rready=1; on rvalid capture rdata, rresp[1] -> RESP.
//   - RESP: resp_valid=1, data/err stable; on resp_ready -> IDLE. Stall of any length is held.
//   - Never a new request while busy: req_ready=0 in every state except IDLE.
//   - AXI valid signals never drop before their handshake; addr/data stable while valid.
//   - Minimum latency: request accept edge N -> AXI valid in cycle N+1 -> resp_valid in the cycle
//     after the B/R handshake edge.
// CONFIGURATION
//   RESP_BYPASS_EN defined: in WR_B/RD_R, resp_valid=bvalid/rvalid combinationally with
//     resp_rdata/resp_err driven from rdata/bresp; if resp_ready is also high, go directly to IDLE
//     (one cycle saved); otherwise capture and go to RESP as normal.
//   Not defined: response always registered via RESP; no B/R-to-resp combinational path.
// STRUCTURE
//   axil_pkg: AXI resp codes (OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11),
//     PROT_DEFAULT=3'b000, adapter FSM state encoding.
//   Sub-module: axil_resp_hold (one-entry data/err holding register with valid/ready).
// TESTING (bench: adapter + axil_ram, ADDR_WIDTH=5, DATA_WIDTH=32)
//   1 store addr 1 data 10 strb 4'hF, resp_ready=1 -> exactly one AW and one W handshake; resp_valid 1 cycle, err 0
//   2 load addr 1 after step 1 -> resp_rdata=10, err 0; arvalid seen the cycle after acceptance
//   3 load addr 1, resp_ready=0 for 5 cycles after resp_valid -> rdata stays 10, req_ready stays 0, no new AR
//   4 req_valid held high throughout -> store 20 to addr 1 then load addr 1: second request accepted only
//     after the first response handshake; load returns 20
//   5 rst=0 during WR after AW handshake -> next cycle all valid outputs 0, state IDLE; new store works
//   6 store with strb 4'b0011 of 32'hAABBCCDD over 32'h11223344 -> load returns 32'h1122CCDD

Source files
------------

// File: rtl/axil_mem_req_adapter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axil_mem_req_adapter_pkg
// Brief    : AXI4-Lite response codes, protection default and the adapter
//            FSM state encoding shared by the request adapter files.
// Revision : 1.0 - initial release
// ============================================================================
package axil_mem_req_adapter_pkg;

    localparam logic [1:0] c_resp_okay   = 2'b00;
    localparam logic [1:0] c_resp_exokay = 2'b01;
    localparam logic [1:0] c_resp_slverr = 2'b10;
    localparam logic [1:0] c_resp_decerr = 2'b11;

    localparam logic [2:0] c_prot_default = 3'b000;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR   = 3'd1,
        S_WR_B = 3'd2,
        S_RD_A = 3'd3,
        S_RD_R = 3'd4,
        S_RESP = 3'd5
    } state_t;

    // SLVERR and DECERR are reported to the core as a single error bit.
    function automatic logic resp_is_err(input logic [1:0] resp);
        logic err;
        err = 1'b0;
        case (resp)
            c_resp_okay, c_resp_exokay:  err = 1'b0;
            c_resp_slverr, c_resp_decerr: err = 1'b1;
            default:                      err = 1'b0;
        endcase
        return err;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axil_mem_req_adapter_if.sv
`default_nettype none
// ============================================================================
// Module   : axil_mem_req_adapter_if
// Brief    : Core request/response channel plus AXI4-Lite master channels.
//            master = adapter view, slave = environment (core + AXI slave).
// Revision : 1.0 - initial release
// ============================================================================
interface axil_mem_req_adapter_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_wen;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [STRB_WIDTH-1:0] req_wstrb;

    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_err;

    logic [ADDR_WIDTH-1:0] m_axil_awaddr;
    logic [2:0]            m_axil_awprot;
    logic                  m_axil_awvalid;
    logic                  m_axil_awready;
    logic [DATA_WIDTH-1:0] m_axil_wdata;
    logic [STRB_WIDTH-1:0] m_axil_wstrb;
    logic                  m_axil_wvalid;
    logic                  m_axil_wready;
    logic [1:0]            m_axil_bresp;
    logic                  m_axil_bvalid;
    logic                  m_axil_bready;
    logic [ADDR_WIDTH-1:0] m_axil_araddr;
    logic [2:0]            m_axil_arprot;
    logic                  m_axil_arvalid;
    logic                  m_axil_arready;
    logic [DATA_WIDTH-1:0] m_axil_rdata;
    logic [1:0]            m_axil_rresp;
    logic                  m_axil_rvalid;
    logic                  m_axil_rready;

    modport master (
        input  req_valid, req_wen, req_addr, req_wdata, req_wstrb,
        output req_ready,
        output resp_valid, resp_rdata, resp_err,
        input  resp_ready,
        output m_axil_awaddr, m_axil_awprot, m_axil_awvalid,
        input  m_axil_awready,
        output m_axil_wdata, m_axil_wstrb, m_axil_wvalid,
        input  m_axil_wready,
        input  m_axil_bresp, m_axil_bvalid,
        output m_axil_bready,
        output m_axil_araddr, m_axil_arprot, m_axil_arvalid,
        input  m_axil_arready,
        input  m_axil_rdata, m_axil_rresp, m_axil_rvalid,
        output m_axil_rready
    );

    modport slave (
        output req_valid, req_wen, req_addr, req_wdata, req_wstrb,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_err,
        output resp_ready,
        input  m_axil_awaddr, m_axil_awprot, m_axil_awvalid,
        output m_axil_awready,
        input  m_axil_wdata, m_axil_wstrb, m_axil_wvalid,
        output m_axil_wready,
        output m_axil_bresp, m_axil_bvalid,
        input  m_axil_bready,
        input  m_axil_araddr, m_axil_arprot, m_axil_arvalid,
        output m_axil_arready,
        output m_axil_rdata, m_axil_rresp, m_axil_rvalid,
        input  m_axil_rready
    );

endinterface
`default_nettype wire

// File: rtl/axil_mem_req_adapter_resp_hold.sv
`default_nettype none
// ============================================================================
// Module   : axil_mem_req_adapter_resp_hold
// Brief    : One-entry data/err holding register with valid/ready output so a
//            completed response survives an arbitrarily long core stall.
// Revision : 1.0 - initial release
// ============================================================================
module axil_mem_req_adapter_resp_hold #(
    parameter int DATA_WIDTH = 32
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  load,
    input  wire logic [DATA_WIDTH-1:0] load_data,
    input  wire logic                  load_err,
    output logic                       valid,
    input  wire logic                  ready,
    output logic [DATA_WIDTH-1:0]      data,
    output logic                       err
);

    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_err;

    // Capture on load; valid clears only when the consumer takes the entry.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_err   <= 1'b0;
        end else if (load) begin
            r_valid <= 1'b1;
            r_data  <= load_data;
            r_err   <= load_err;
        end else if (r_valid && ready) begin
            r_valid <= 1'b0;
        end
    end

    assign valid = r_valid;
    assign data  = r_data;
    assign err   = r_err;

endmodule
`default_nettype wire

// File: rtl/axil_mem_req_adapter.sv
`default_nettype none
// ============================================================================
// Module   : axil_mem_req_adapter
// Brief    : Converts a one-beat valid/ready load/store request into a single
//            AXI4-Lite write (AW+W+B) or read (AR+R) and holds the response
//            until the core accepts it. One transaction in flight.
//            Optional macro RESP_BYPASS_EN: forward B/R straight to the
//            response port and skip the holding stage when the core is ready.
// Revision : 1.0 - initial release
// ============================================================================
module axil_mem_req_adapter
    import axil_mem_req_adapter_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  wire logic               clk,
    input  wire logic               rst,
    axil_mem_req_adapter_if.master  bus
);

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB_WIDTH-1:0] r_wstrb;
    logic                  r_aw_done;
    logic                  r_w_done;

    logic                  w_req_ready;
    logic                  w_awvalid;
    logic                  w_wvalid;
    logic                  w_bready;
    logic                  w_arvalid;
    logic                  w_rready;
    logic                  w_hold_load;
    logic [DATA_WIDTH-1:0] w_hold_data;
    logic                  w_hold_err;
    logic                  w_byp_valid;
    logic [DATA_WIDTH-1:0] w_byp_data;
    logic                  w_byp_err;
    logic                  w_held_valid;
    logic [DATA_WIDTH-1:0] w_held_data;
    logic                  w_held_err;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_next;
    end

    // Request latch and per-channel write handshake tracking.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else if (r_state == S_IDLE && bus.req_valid) begin
            r_addr    <= bus.req_addr;
            r_wdata   <= bus.req_wdata;
            r_wstrb   <= bus.req_wstrb;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else if (r_state == S_WR) begin
            if (w_awvalid && bus.m_axil_awready) r_aw_done <= 1'b1;
            if (w_wvalid && bus.m_axil_wready)   r_w_done  <= 1'b1;
        end
    end

    // Next-state and channel control decode.
    always_comb begin
        w_state_next = r_state;
        w_req_ready  = 1'b0;
        w_awvalid    = 1'b0;
        w_wvalid     = 1'b0;
        w_bready     = 1'b0;
        w_arvalid    = 1'b0;
        w_rready     = 1'b0;
        w_hold_load  = 1'b0;
        w_hold_data  = '0;
        w_hold_err   = 1'b0;
        w_byp_valid  = 1'b0;
        w_byp_data   = '0;
        w_byp_err    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_req_ready = 1'b1;
                if (bus.req_valid) w_state_next = bus.req_wen ? S_WR : S_RD_A;
            end
            S_WR: begin
                w_awvalid = !r_aw_done;
                w_wvalid  = !r_w_done;
                if ((r_aw_done || bus.m_axil_awready) && (r_w_done || bus.m_axil_wready))
                    w_state_next = S_WR_B;
            end
            S_WR_B: begin
                w_bready = 1'b1;
                if (bus.m_axil_bvalid) begin
                    w_hold_data = '0;
                    w_hold_err  = resp_is_err(bus.m_axil_bresp);
`ifdef RESP_BYPASS_EN
                    w_byp_valid = 1'b1;
                    w_byp_data  = '0;
                    w_byp_err   = resp_is_err(bus.m_axil_bresp);
                    w_hold_load = !bus.resp_ready;
                    w_state_next = bus.resp_ready ? S_IDLE : S_RESP;
`else
                    w_hold_load  = 1'b1;
                    w_state_next = S_RESP;
`endif
                end
            end
            S_RD_A: begin
                w_arvalid = 1'b1;
                if (bus.m_axil_arready) w_state_next = S_RD_R;
            end
            S_RD_R: begin
                w_rready = 1'b1;
                if (bus.m_axil_rvalid) begin
                    w_hold_data = bus.m_axil_rdata;
                    w_hold_err  = resp_is_err(bus.m_axil_rresp);
`ifdef RESP_BYPASS_EN
                    w_byp_valid = 1'b1;
                    w_byp_data  = bus.m_axil_rdata;
                    w_byp_err   = resp_is_err(bus.m_axil_rresp);
                    w_hold_load = !bus.resp_ready;
                    w_state_next = bus.resp_ready ? S_IDLE : S_RESP;
`else
                    w_hold_load  = 1'b1;
                    w_state_next = S_RESP;
`endif
                end
            end
            S_RESP: begin
                if (bus.resp_ready) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    axil_mem_req_adapter_resp_hold #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_resp_hold (
        .clk       (clk),
        .rst       (rst),
        .load      (w_hold_load),
        .load_data (w_hold_data),
        .load_err  (w_hold_err),
        .valid     (w_held_valid),
        .ready     (bus.resp_ready),
        .data      (w_held_data),
        .err       (w_held_err)
    );

    // req_ready stays low while reset is asserted, even though the state is IDLE.
    assign bus.req_ready      = w_req_ready & rst;
    assign bus.resp_valid     = w_held_valid | w_byp_valid;
    assign bus.resp_rdata     = w_byp_valid ? w_byp_data : w_held_data;
    assign bus.resp_err       = w_byp_valid ? w_byp_err  : w_held_err;

    assign bus.m_axil_awaddr  = r_addr;
    assign bus.m_axil_awprot  = c_prot_default;
    assign bus.m_axil_awvalid = w_awvalid;
    assign bus.m_axil_wdata   = r_wdata;
    assign bus.m_axil_wstrb   = r_wstrb;
    assign bus.m_axil_wvalid  = w_wvalid;
    assign bus.m_axil_bready  = w_bready;
    assign bus.m_axil_araddr  = r_addr;
    assign bus.m_axil_arprot  = c_prot_default;
    assign bus.m_axil_arvalid = w_arvalid;
    assign bus.m_axil_rready  = w_rready;

endmodule
`default_nettype wire

// File: tb/tb_axil_mem_req_adapter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_axil_mem_req_adapter
// Brief    : Directed self-checking bench: adapter plus a small AXI4-Lite RAM
//            model (8 words, addresses >= 24 answer SLVERR).
// Revision : 1.0 - initial release
// ============================================================================
module tb_axil_mem_req_adapter;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int SW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axil_mem_req_adapter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW)) bus ();

    axil_mem_req_adapter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- AXI4-Lite RAM model ----------------
    logic [31:0] mem [8];
    logic        s_aw_got, s_w_got, s_bvalid, s_rvalid, w_stall;
    logic [4:0]  s_awaddr;
    logic [31:0] s_wdata, s_rdata;
    logic [3:0]  s_wstrb;
    logic [1:0]  s_bresp, s_rresp;

    assign bus.m_axil_awready = !s_aw_got;
    assign bus.m_axil_wready  = !s_w_got && !w_stall;
    assign bus.m_axil_bvalid  = s_bvalid;
    assign bus.m_axil_bresp   = s_bresp;
    assign bus.m_axil_arready = !s_rvalid;
    assign bus.m_axil_rvalid  = s_rvalid;
    assign bus.m_axil_rdata   = s_rdata;
    assign bus.m_axil_rresp   = s_rresp;

    always @(posedge clk) begin
        if (!rst) begin
            s_aw_got <= 1'b0; s_w_got <= 1'b0; s_bvalid <= 1'b0; s_rvalid <= 1'b0;
            s_awaddr <= '0; s_wdata <= '0; s_wstrb <= '0; s_rdata <= '0;
            s_bresp <= 2'b00; s_rresp <= 2'b00;
            for (int i = 0; i < 8; i++) mem[i] <= 32'h0;
        end else begin
            if (bus.m_axil_awvalid && bus.m_axil_awready) begin
                s_aw_got <= 1'b1; s_awaddr <= bus.m_axil_awaddr;
            end
            if (bus.m_axil_wvalid && bus.m_axil_wready) begin
                s_w_got <= 1'b1; s_wdata <= bus.m_axil_wdata; s_wstrb <= bus.m_axil_wstrb;
            end
            if (s_aw_got && s_w_got && !s_bvalid) begin
                s_aw_got <= 1'b0; s_w_got <= 1'b0; s_bvalid <= 1'b1;
                if (s_awaddr >= 5'd24) s_bresp <= 2'b10;
                else begin
                    s_bresp <= 2'b00;
                    for (int b = 0; b < 4; b++)
                        if (s_wstrb[b]) mem[s_awaddr[4:2]][8*b +: 8] <= s_wdata[8*b +: 8];
                end
            end
            if (s_bvalid && bus.m_axil_bready) s_bvalid <= 1'b0;
            if (bus.m_axil_arvalid && bus.m_axil_arready) begin
                s_rvalid <= 1'b1;
                if (bus.m_axil_araddr >= 5'd24) begin s_rdata <= 32'h0; s_rresp <= 2'b10; end
                else begin s_rdata <= mem[bus.m_axil_araddr[4:2]]; s_rresp <= 2'b00; end
            end
            if (s_rvalid && bus.m_axil_rready) s_rvalid <= 1'b0;
        end
    end

    // Handshake counters (never reset; tests use deltas).
    int n_aw = 0, n_w = 0, n_ar = 0;
    always @(posedge clk) begin
        if (rst) begin
            if (bus.m_axil_awvalid && bus.m_axil_awready) n_aw <= n_aw + 1;
            if (bus.m_axil_wvalid && bus.m_axil_wready)   n_w  <= n_w + 1;
            if (bus.m_axil_arvalid && bus.m_axil_arready) n_ar <= n_ar + 1;
        end
    end

    // ---------------- stimulus tasks (called at negedge) ----------------
    task automatic send_req(input logic wen, input logic [4:0] addr,
                            input logic [31:0] wd, input logic [3:0] ws, input string name);
        bit ok;
        ok = 0;
        bus.req_valid = 1'b1; bus.req_wen = wen; bus.req_addr = addr;
        bus.req_wdata = wd; bus.req_wstrb = ws;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (bus.req_ready === 1'b1) ok = 1;
            else @(negedge clk);
        end
        if (!ok) begin
            n_cmp++; n_err++;
            $display("FAIL %s_accept: req_ready never 1 (timeout), required 1", name);
        end
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_resp(input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < 60 && !ok; i++) begin
            if (bus.resp_valid === 1'b1) ok = 1;
            else @(negedge clk);
        end
        if (!ok) begin
            n_cmp++; n_err++;
            $display("FAIL %s_resp: resp_valid never 1 (timeout), required 1", name);
        end
    endtask

    // Full transaction with resp_ready=1; returns observed response.
    task automatic xact(input logic wen, input logic [4:0] addr, input logic [31:0] wd,
                        input logic [3:0] ws, input string name,
                        output logic [31:0] rd, output logic er);
        bus.resp_ready = 1'b1;
        send_req(wen, addr, wd, ws, name);
        wait_resp(name);
        rd = bus.resp_rdata;
        er = bus.resp_err;
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({bus.req_ready, bus.resp_valid, bus.m_axil_awvalid, bus.m_axil_wvalid,
             bus.m_axil_bready, bus.m_axil_arvalid, bus.m_axil_rready} !== 7'b0) begin
            n_err++; $display("FAIL reset_handshakes: got %b required 0000000",
                {bus.req_ready, bus.resp_valid, bus.m_axil_awvalid, bus.m_axil_wvalid,
                 bus.m_axil_bready, bus.m_axil_arvalid, bus.m_axil_rready});
        end
        n_cmp++;
        if ({bus.resp_rdata, bus.resp_err} !== 33'h0) begin
            n_err++; $display("FAIL reset_resp: rdata %h err %b required 0/0", bus.resp_rdata, bus.resp_err);
        end
        n_cmp++;
        if ({bus.m_axil_awprot, bus.m_axil_arprot} !== 6'b0) begin
            n_err++; $display("FAIL reset_prot: got %b required 000000", {bus.m_axil_awprot, bus.m_axil_arprot});
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.req_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_release_req_ready: got %b required 1", bus.req_ready);
        end
    endtask

    task automatic test_store_basic();
        int a0, w0;
        a0 = n_aw; w0 = n_w;
        bus.resp_ready = 1'b1;
        send_req(1'b1, 5'd1, 32'd10, 4'hF, "t1");
        n_cmp++;
        if ({bus.m_axil_awvalid, bus.m_axil_wvalid} !== 2'b11) begin
            n_err++; $display("FAIL t1_aw_w_valid: got %b required 11", {bus.m_axil_awvalid, bus.m_axil_wvalid});
        end
        wait_resp("t1");
        n_cmp++;
        if ({bus.resp_rdata, bus.resp_err} !== 33'h0) begin
            n_err++; $display("FAIL t1_resp: rdata %h err %b required 0/0", bus.resp_rdata, bus.resp_err);
        end
        @(posedge clk); @(negedge clk);
        n_cmp++;
        if (bus.resp_valid !== 1'b0) begin
            n_err++; $display("FAIL t1_resp_one_cycle: resp_valid %b required 0", bus.resp_valid);
        end
        n_cmp++;
        if ((n_aw - a0) != 1 || (n_w - w0) != 1) begin
            n_err++; $display("FAIL t1_handshake_count: aw %0d w %0d required 1/1", n_aw - a0, n_w - w0);
        end
    endtask

    task automatic test_load_basic();
        bus.resp_ready = 1'b1;
        send_req(1'b0, 5'd1, 32'h0, 4'h0, "t2");
        n_cmp++;
        if (bus.m_axil_arvalid !== 1'b1) begin
            n_err++; $display("FAIL t2_arvalid_latency: got %b required 1", bus.m_axil_arvalid);
        end
        wait_resp("t2");
        n_cmp++;
        if (bus.resp_rdata !== 32'd10 || bus.resp_err !== 1'b0) begin
            n_err++; $display("FAIL t2_load: rdata %h err %b required 0000000a/0", bus.resp_rdata, bus.resp_err);
        end
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_stall();
        int ar0;
        bus.resp_ready = 1'b0;
        send_req(1'b0, 5'd1, 32'h0, 4'h0, "t3");
        wait_resp("t3");
        ar0 = n_ar;
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'd10 || bus.req_ready !== 1'b0
                || bus.m_axil_arvalid !== 1'b0) begin
                n_err++; $display("FAIL t3_stall_hold[%0d]: valid %b rdata %h req_ready %b arvalid %b required 1/0000000a/0/0",
                    i, bus.resp_valid, bus.resp_rdata, bus.req_ready, bus.m_axil_arvalid);
            end
            @(negedge clk);
        end
        n_cmp++;
        if (n_ar != ar0) begin
            n_err++; $display("FAIL t3_no_new_ar: extra AR %0d required 0", n_ar - ar0);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        n_cmp++;
        if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            n_err++; $display("FAIL t3_release: resp_valid %b req_ready %b required 0/1", bus.resp_valid, bus.req_ready);
        end
    endtask

    task automatic test_back_to_back();
        bit resp_seen, accepted, ok;
        logic [31:0] rd;
        logic er;
        resp_seen = 0; accepted = 0; ok = 0;
        bus.resp_ready = 1'b1;
        bus.req_valid = 1'b1; bus.req_wen = 1'b1; bus.req_addr = 5'd1;
        bus.req_wdata = 32'd20; bus.req_wstrb = 4'hF;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (bus.req_ready === 1'b1) ok = 1; else @(negedge clk);
        end
        @(posedge clk); @(negedge clk);
        bus.req_wen = 1'b0; bus.req_wdata = 32'h0; bus.req_wstrb = 4'h0;
        for (int i = 0; i < 60 && !accepted; i++) begin
            if (bus.resp_valid === 1'b1 && !resp_seen) begin
                resp_seen = 1;
                n_cmp++;
                if (bus.resp_rdata !== 32'h0 || bus.resp_err !== 1'b0) begin
                    n_err++; $display("FAIL t4_store_resp: rdata %h err %b required 0/0", bus.resp_rdata, bus.resp_err);
                end
            end else if (bus.req_ready === 1'b1) begin
                accepted = 1;
            end
            if (!accepted) @(negedge clk);
        end
        n_cmp++;
        if (!(accepted && resp_seen)) begin
            n_err++; $display("FAIL t4_order: accepted %b resp_seen %b required 1/1", accepted, resp_seen);
        end
        @(posedge clk); @(negedge clk);
        bus.req_valid = 1'b0;
        wait_resp("t4");
        rd = bus.resp_rdata; er = bus.resp_err;
        @(posedge clk); @(negedge clk);
        n_cmp++;
        if (rd !== 32'd20 || er !== 1'b0) begin
            n_err++; $display("FAIL t4_load: rdata %h err %b required 00000014/0", rd, er);
        end
    endtask

    task automatic test_reset_mid_write();
        int a0;
        bit ok;
        logic [31:0] rd;
        logic er;
        ok = 0;
        w_stall = 1'b1;
        a0 = n_aw;
        bus.resp_ready = 1'b1;
        send_req(1'b1, 5'd4, 32'h55, 4'hF, "t5");
        for (int i = 0; i < 20 && !ok; i++) begin
            if (n_aw != a0) ok = 1; else @(negedge clk);
        end
        n_cmp++;
        if (!ok || bus.m_axil_awvalid !== 1'b0 || bus.m_axil_wvalid !== 1'b1) begin
            n_err++; $display("FAIL t5_partial_write: aw_hs %b awvalid %b wvalid %b required 1/0/1",
                ok, bus.m_axil_awvalid, bus.m_axil_wvalid);
        end
        rst = 1'b0;
        @(posedge clk); @(negedge clk);
        n_cmp++;
        if ({bus.req_ready, bus.resp_valid, bus.m_axil_awvalid, bus.m_axil_wvalid,
             bus.m_axil_bready, bus.m_axil_arvalid, bus.m_axil_rready} !== 7'b0) begin
            n_err++; $display("FAIL t5_abort: got %b required 0000000",
                {bus.req_ready, bus.resp_valid, bus.m_axil_awvalid, bus.m_axil_wvalid,
                 bus.m_axil_bready, bus.m_axil_arvalid, bus.m_axil_rready});
        end
        rst = 1'b1; w_stall = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.req_ready !== 1'b1) begin
            n_err++; $display("FAIL t5_idle_after: req_ready %b required 1", bus.req_ready);
        end
        xact(1'b1, 5'd4, 32'h77, 4'hF, "t5s", rd, er);
        n_cmp++;
        if (er !== 1'b0) begin
            n_err++; $display("FAIL t5_store_err: err %b required 0", er);
        end
        xact(1'b0, 5'd4, 32'h0, 4'h0, "t5l", rd, er);
        n_cmp++;
        if (rd !== 32'h77 || er !== 1'b0) begin
            n_err++; $display("FAIL t5_load: rdata %h err %b required 00000077/0", rd, er);
        end
    endtask

    task automatic test_strobe();
        logic [31:0] rd;
        logic er;
        xact(1'b1, 5'd8, 32'h11223344, 4'hF, "t6a", rd, er);
        xact(1'b1, 5'd8, 32'hAABBCCDD, 4'b0011, "t6b", rd, er);
        xact(1'b0, 5'd8, 32'h0, 4'h0, "t6c", rd, er);
        n_cmp++;
        if (rd !== 32'h1122CCDD || er !== 1'b0) begin
            n_err++; $display("FAIL t6_strobe: rdata %h err %b required 1122ccdd/0", rd, er);
        end
    endtask

    task automatic test_error();
        logic [31:0] rd;
        logic er;
        xact(1'b1, 5'd28, 32'hDEADBEEF, 4'hF, "t7s", rd, er);
        n_cmp++;
        if (rd !== 32'h0 || er !== 1'b1) begin
            n_err++; $display("FAIL t7_store_slverr: rdata %h err %b required 0/1", rd, er);
        end
        xact(1'b0, 5'd28, 32'h0, 4'h0, "t7l", rd, er);
        n_cmp++;
        if (rd !== 32'h0 || er !== 1'b1) begin
            n_err++; $display("FAIL t7_load_slverr: rdata %h err %b required 0/1", rd, er);
        end
    endtask

    initial begin
        rst = 1'b0; w_stall = 1'b0;
        bus.req_valid = 1'b0; bus.req_wen = 1'b0; bus.req_addr = '0;
        bus.req_wdata = '0; bus.req_wstrb = '0; bus.resp_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_store_basic();
        test_load_basic();
        test_stall();
        test_back_to_back();
        test_reset_mid_write();
        test_strobe();
        test_error();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
